// File: rtl/uart_sender_if.sv
// Byte-write and serial-line bundle between the CPU peripheral side and uart_sender.
interface uart_sender_if;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_ovf;
  logic       uart_tx;

  modport master (output tx_data, tx_en, input tx_ready, tx_busy, tx_ovf, uart_tx);
  modport slave  (input tx_data, tx_en, output tx_ready, tx_busy, tx_ovf, uart_tx);
endinterface

// File: rtl/uart_sender.sv
// 8N1 UART transmitter with a small byte FIFO; every bit is held OVERSAMPLE clocks.
// Frames are sent back to back while the FIFO holds data.
module uart_sender #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic          br_clk_16,
  input logic          reset,
  uart_sender_if.slave bus
);
  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned CW       = DEPTH_LOG2 + 1;
  localparam int unsigned STOP_LEN = OVERSAMPLE * STOP_BITS;
  localparam int unsigned CNT_W    = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_n;
  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [2:0]            bit_idx, bit_idx_n;
  logic [7:0]            shift, shift_n;
  logic                  line_n;
  logic                  push_c, pop_c;

  // tx_ready is the registered pre-edge "not full", so a full FIFO rejects even on a pop cycle
  assign push_c = bus.tx_en && bus.tx_ready;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop_c     = 1'b0;
    line_n    = 1'b1;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (count != '0) begin
          pop_c   = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
        end
      end
      START: begin
        line_n = 1'b0;
        if (cnt == CNT_W'(OVERSAMPLE - 1)) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        line_n = shift[bit_idx];
        if (cnt == CNT_W'(OVERSAMPLE - 1)) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == CNT_W'(STOP_LEN - 1)) begin
          cnt_n = '0;
          if (count != '0) begin
            pop_c   = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    count_n = count;
    unique case ({push_c, pop_c})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge br_clk_16) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus.uart_tx  <= 1'b1;
      bus.tx_ready <= 1'b1;
      bus.tx_busy  <= 1'b0;
      bus.tx_ovf   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      count   <= count_n;
      if (push_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop_c)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      bus.uart_tx  <= line_n;
      bus.tx_ready <= (count_n != CW'(DEPTH));
      bus.tx_busy  <= (count_n != '0) || (state_n != IDLE);
      bus.tx_ovf   <= bus.tx_ovf || (bus.tx_en && !bus.tx_ready);
    end
  end

  // Storage needs no reset: pointers and count define what is valid
  always_ff @(posedge br_clk_16) begin
    if (push_c) mem[wr_ptr] <= bus.tx_data;
  end
endmodule

// File: tb/tb_uart_sender.sv
// Directed bench for uart_sender: a default build and a two-stop-bit build share clock and reset.
module tb_uart_sender;
  logic br_clk_16 = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 br_clk_16 = ~br_clk_16;

  uart_sender_if if1 ();
  uart_sender_if if2 ();

  uart_sender dut (.br_clk_16(br_clk_16), .reset(reset), .bus(if1.slave));
  uart_sender #(.STOP_BITS(2)) dut2 (.br_clk_16(br_clk_16), .reset(reset), .bus(if2.slave));

  task automatic tick();
    @(posedge br_clk_16);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic line(input int w);
    return (w != 0) ? if2.uart_tx : if1.uart_tx;
  endfunction

  // Checks every sample of one frame from index 'skip'; sample 0 is the first low start cycle.
  task automatic check_frame(input int w, input logic [7:0] b, input int sb, input int skip);
    logic [10:0] bits;
    bits = {1'b1, 1'b1, b, 1'b0};
    for (int i = skip; i < (10 + sb - 1) * 16; i++) begin
      chk("frame_bit", 8'(line(w)), 8'(bits[i / 16]));
      tick();
    end
  endtask

  task automatic wait_fall(input int w, input int budget);
    int k = 0;
    while (line(w) !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    chk("wait_fall", 8'(line(w)), 8'h00);
  endtask

  task automatic write1(input logic [7:0] b);
    if1.tx_data = b;
    if1.tx_en   = 1'b1;
    tick();
    if1.tx_en   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    if1.tx_en = 1'b0; if1.tx_data = '0;
    if2.tx_en = 1'b0; if2.tx_data = '0;
    repeat (3) tick();
    chk("rst_tx",    8'(if1.uart_tx),  8'h01);
    chk("rst_ready", 8'(if1.tx_ready), 8'h01);
    chk("rst_busy",  8'(if1.tx_busy),  8'h00);
    chk("rst_ovf",   8'(if1.tx_ovf),   8'h00);
    chk("rst_tx2",   8'(if2.uart_tx),  8'h01);
    reset = 1'b0;

    // Idle after reset
    repeat (50) begin
      tick();
      chk("idle_tx",    8'(if1.uart_tx),  8'h01);
      chk("idle_ready", 8'(if1.tx_ready), 8'h01);
      chk("idle_busy",  8'(if1.tx_busy),  8'h00);
      chk("idle_ovf",   8'(if1.tx_ovf),   8'h00);
    end

    // Single byte 0xA5: line falls exactly two edges after the accepting edge
    write1(8'hA5);
    chk("a5_busy", 8'(if1.tx_busy), 8'h01);
    chk("a5_lat0", 8'(if1.uart_tx), 8'h01);
    tick();
    chk("a5_lat1", 8'(if1.uart_tx), 8'h01);
    tick();
    check_frame(0, 8'hA5, 1, 0);
    chk("a5_busy_end", 8'(if1.tx_busy), 8'h00);
    chk("a5_tx_end",   8'(if1.uart_tx), 8'h01);

    // Three consecutive writes: contiguous frames, no idle gap
    if1.tx_en = 1'b1;
    if1.tx_data = 8'h00; tick();
    if1.tx_data = 8'hFF; tick();
    if1.tx_data = 8'h55; tick();
    if1.tx_en = 1'b0;
    check_frame(0, 8'h00, 1, 0);
    check_frame(0, 8'hFF, 1, 0);
    check_frame(0, 8'h55, 1, 0);
    chk("b2b_busy_end", 8'(if1.tx_busy), 8'h00);
    chk("b2b_tx_end",   8'(if1.uart_tx), 8'h01);

    // Fill: five accepted (first pops after one edge), sixth dropped with sticky overflow
    if1.tx_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", 8'(if1.tx_ready), 8'h01);
      if1.tx_data = 8'(8'h11 + i);
      tick();
    end
    chk("full_ready", 8'(if1.tx_ready), 8'h00);
    chk("full_ovf0",  8'(if1.tx_ovf),   8'h00);
    if1.tx_data = 8'h16;
    tick();
    if1.tx_en = 1'b0;
    chk("full_ovf1", 8'(if1.tx_ovf), 8'h01);
    check_frame(0, 8'h11, 1, 3);
    for (int i = 1; i < 5; i++) check_frame(0, 8'(8'h11 + i), 1, 0);
    repeat (20) begin
      chk("drop_tx",   8'(if1.uart_tx), 8'h01);
      chk("drop_busy", 8'(if1.tx_busy), 8'h00);
      chk("drop_ovf",  8'(if1.tx_ovf),  8'h01);
      tick();
    end

    // Reset at cycle 70 of a 0x3C frame, then a clean 0xC3
    write1(8'h3C);
    wait_fall(0, 10);
    repeat (70) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_tx",    8'(if1.uart_tx),  8'h01);
    chk("mrst_busy",  8'(if1.tx_busy),  8'h00);
    chk("mrst_ready", 8'(if1.tx_ready), 8'h01);
    chk("mrst_ovf",   8'(if1.tx_ovf),   8'h00);
    repeat (200) begin
      tick();
      chk("mrst_quiet_tx",   8'(if1.uart_tx), 8'h01);
      chk("mrst_quiet_busy", 8'(if1.tx_busy), 8'h00);
    end
    write1(8'hC3);
    tick();
    tick();
    check_frame(0, 8'hC3, 1, 0);
    chk("c3_busy_end", 8'(if1.tx_busy), 8'h00);

    // Two stop bits: 176-cycle frame
    if2.tx_data = 8'h81;
    if2.tx_en   = 1'b1;
    tick();
    if2.tx_en   = 1'b0;
    tick();
    chk("sb2_lat1", 8'(if2.uart_tx), 8'h01);
    tick();
    check_frame(1, 8'h81, 2, 0);
    chk("sb2_busy_end", 8'(if2.tx_busy), 8'h00);
    chk("sb2_tx_end",   8'(if2.uart_tx), 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
